// File: rtl/pwm_width_if.sv
// ---------------------------------------------------------------------------
// pwm_width_if
// Result bus from the pulse-width decoder to its consumer.
// Handshake: the producer raises width_valid with width_out/overflow/frame_err
// stable; the result transfers on a clock edge where width_valid and
// width_ready are both high. The producer holds everything until that edge.
// Signals:
//   width_out   - recovered code (producer -> consumer)
//   width_valid - width_out and flags are valid (producer -> consumer)
//   overflow    - high-time counter saturated (qualified by width_valid)
//   frame_err   - done strobe missing from its window (qualified by width_valid)
//   width_ready - consumer accepts the result (consumer -> producer)
// ---------------------------------------------------------------------------
interface pwm_width_if #(
   parameter int CNT_W = 8
);
   logic [CNT_W-1:0] width_out;
   logic             width_valid;
   logic             width_ready;
   logic             overflow;
   logic             frame_err;

   modport master (
      output width_out,
      output width_valid,
      output overflow,
      output frame_err,
      input  width_ready
   );

   modport slave (
      input  width_out,
      input  width_valid,
      input  overflow,
      input  frame_err,
      output width_ready
   );
endinterface

// File: rtl/pwm_width_decoder.sv
// ---------------------------------------------------------------------------
// pwm_width_decoder
// Receive stage for the pulse-width encoder. Synchronises the encoder's pulse
// and done strobe, counts pulse high time in clk cycles, subtracts OFFSET and
// presents the recovered code with error flags on a valid/ready register.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   pulse_in    - encoder pulse (asynchronous)
//   done_in     - encoder done strobe (asynchronous)
//   enable      - measurement enable; low aborts a measurement
//   out_if      - result bus (width_out/width_valid/width_ready/overflow/frame_err)
//   overrun     - one-cycle pulse when a result is dropped (output full)
//   busy        - FSM not in IDLE
//   state_dbg   - current FSM state encoding
// ---------------------------------------------------------------------------
module pwm_width_decoder #(
   parameter int CNT_W       = 8,
   parameter int OFFSET      = 1,
   parameter int SYNC_STAGES = 2,
   parameter int DONE_WINDOW = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pulse_in,
   input  logic             done_in,
   input  logic             enable,
   pwm_width_if.master      out_if,
   output logic             overrun,
   output logic             busy,
   output logic [1:0]       state_dbg
);

   localparam int               WIN_W    = $clog2(DONE_WINDOW + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] OFFSET_C = CNT_W'(OFFSET);
   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(DONE_WINDOW - 1);

   typedef enum logic [1:0] {
      IDLE      = 2'b00,
      MEASURE   = 2'b01,
      WAIT_DONE = 2'b10
   } state_t;

   state_t state_q, state_d;

   logic [SYNC_STAGES-1:0] pulse_sync_q, pulse_sync_d;
   logic [SYNC_STAGES-1:0] done_sync_q, done_sync_d;
   logic                   pulse_d_q, pulse_d_d;
   logic [CNT_W-1:0]       count_q, count_d;
   logic                   ovf_q, ovf_d;
   logic [WIN_W-1:0]       win_q, win_d;
   logic [CNT_W-1:0]       width_q, width_d;
   logic                   valid_q, valid_d;
   logic                   oflag_q, oflag_d;
   logic                   ferr_q, ferr_d;
   logic                   overrun_q, overrun_d;

   logic                   pulse_s, done_s, rise;
   logic                   pub, pub_ferr;
   logic [CNT_W-1:0]       result;

   assign pulse_s = pulse_sync_q[SYNC_STAGES-1];
   assign done_s  = done_sync_q[SYNC_STAGES-1];
   assign rise    = pulse_s & ~pulse_d_q;

   // Measured count minus the encoder's extra high cycle, clamped at zero.
   assign result = (count_q >= OFFSET_C) ? (count_q - OFFSET_C) : '0;

   always_comb begin
      pulse_sync_d = {pulse_sync_q[SYNC_STAGES-2:0], pulse_in};
      done_sync_d  = {done_sync_q[SYNC_STAGES-2:0], done_in};
      pulse_d_d    = pulse_s;

      state_d  = state_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      win_d    = win_q;
      pub      = 1'b0;
      pub_ferr = 1'b0;

      case (state_q)
         IDLE: begin
            // Edge-triggered start: a pulse already high when enable rises
            // has no edge left and is skipped.
            if (rise && enable) begin
               state_d = MEASURE;
               count_d = CNT_W'(1);
               ovf_d   = 1'b0;
            end
         end
         MEASURE: begin
            if (!enable) begin
               state_d = IDLE;
            end else if (pulse_s) begin
               if (count_q == CNT_MAX) ovf_d = 1'b1;
               else                    count_d = count_q + CNT_W'(1);
            end else if (done_s) begin
               pub     = 1'b1;
               state_d = IDLE;
            end else begin
               state_d = WAIT_DONE;
               win_d   = WIN_W'(1);
            end
         end
         WAIT_DONE: begin
            if (!enable) begin
               state_d = IDLE;
            end else if (done_s) begin
               pub     = 1'b1;
               state_d = IDLE;
            end else if (rise || (win_q == WIN_LAST)) begin
               // A new pulse closes the window early; that pulse is not
               // measured because its edge is consumed here.
               pub      = 1'b1;
               pub_ferr = 1'b1;
               state_d  = IDLE;
            end else begin
               win_d = win_q + WIN_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      width_d   = width_q;
      valid_d   = valid_q;
      oflag_d   = oflag_q;
      ferr_d    = ferr_q;
      overrun_d = 1'b0;

      if (valid_q && out_if.width_ready) valid_d = 1'b0;

      if (pub) begin
         if (!valid_q || out_if.width_ready) begin
            width_d = result;
            oflag_d = ovf_q;
            ferr_d  = pub_ferr;
            valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         pulse_sync_q <= '0;
         done_sync_q  <= '0;
         pulse_d_q    <= 1'b0;
         count_q      <= '0;
         ovf_q        <= 1'b0;
         win_q        <= '0;
         width_q      <= '0;
         valid_q      <= 1'b0;
         oflag_q      <= 1'b0;
         ferr_q       <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         pulse_sync_q <= pulse_sync_d;
         done_sync_q  <= done_sync_d;
         pulse_d_q    <= pulse_d_d;
         count_q      <= count_d;
         ovf_q        <= ovf_d;
         win_q        <= win_d;
         width_q      <= width_d;
         valid_q      <= valid_d;
         oflag_q      <= oflag_d;
         ferr_q       <= ferr_d;
         overrun_q    <= overrun_d;
      end
   end

   assign out_if.width_out   = width_q;
   assign out_if.width_valid = valid_q;
   assign out_if.overflow    = oflag_q;
   assign out_if.frame_err   = ferr_q;
   assign overrun            = overrun_q;
   assign busy               = (state_q != IDLE);
   assign state_dbg          = state_q;

endmodule

// File: tb/tb_pwm_width_decoder.sv
// ---------------------------------------------------------------------------
// tb_pwm_width_decoder
// Drives encoder-style frames (high time h, done strobe d cycles after the
// fall, or none) and compares every accepted result with a frame-level model.
// ---------------------------------------------------------------------------
module tb_pwm_width_decoder;
   localparam int CNT_W       = 8;
   localparam int OFFSET      = 1;
   localparam int SYNC_STAGES = 2;
   localparam int DONE_WINDOW = 2;
   localparam int NO_DONE     = 9;

   // clock / reset
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic pulse_in = 1'b0;
   logic done_in = 1'b0;
   logic enable = 1'b0;
   logic overrun, busy;
   logic [1:0] state_dbg;

   always #5 clk = ~clk;

   pwm_width_if #(.CNT_W(CNT_W)) out_if ();

   pwm_width_decoder #(
      .CNT_W(CNT_W), .OFFSET(OFFSET), .SYNC_STAGES(SYNC_STAGES), .DONE_WINDOW(DONE_WINDOW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .pulse_in(pulse_in), .done_in(done_in),
      .enable(enable), .out_if(out_if), .overrun(overrun), .busy(busy),
      .state_dbg(state_dbg)
   );

   int cyc = 0;
   always @(posedge clk) cyc++;

   // scoreboard
   int n_cmp = 0;
   int n_err = 0;
   logic [CNT_W+1:0] exp_q[$];
   logic [CNT_W+1:0] mon_e;
   int ovr_cnt = 0;
   int valid_cnt = 0;
   int first_valid_cyc = -1;
   int done_cyc = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Frame-level reference: {overflow, frame_err, code}.
   function automatic logic [CNT_W+1:0] model(input int h, input int d);
      int max_cnt, cnt, w;
      logic ovf, ferr;
      max_cnt = (1 << CNT_W) - 1;
      cnt  = (h > max_cnt) ? max_cnt : h;
      w    = (cnt >= OFFSET) ? cnt - OFFSET : 0;
      ovf  = (h > max_cnt);
      ferr = (d >= DONE_WINDOW);
      return {ovf, ferr, CNT_W'(w)};
   endfunction

   always @(negedge clk) begin
      if (overrun) ovr_cnt++;
      if (out_if.width_valid) begin
         valid_cnt++;
         if (first_valid_cyc < 0) first_valid_cyc = cyc;
      end
      if (out_if.width_valid && out_if.width_ready) begin
         if (exp_q.size() == 0) begin
            check("sb_unexpected_valid", 32'(out_if.width_valid), 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("sb_width", 32'(out_if.width_out), 32'(mon_e[CNT_W-1:0]));
            check("sb_frame_err", 32'(out_if.frame_err), 32'(mon_e[CNT_W]));
            check("sb_overflow", 32'(out_if.overflow), 32'(mon_e[CNT_W+1]));
         end
      end
   end

   // driver tasks
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input int h, input int d, input bit push);
      if (push) exp_q.push_back(model(h, d));
      pulse_in = 1'b1;
      tick(h);
      pulse_in = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i == d) begin
            done_in  = 1'b1;
            done_cyc = cyc;
         end
         tick(1);
         done_in = 1'b0;
      end
      tick(6);
   endtask

   initial begin
      #100000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      out_if.width_ready = 1'b0;
      tick(3);
      check("rst_valid", 32'(out_if.width_valid), 0);
      check("rst_width", 32'(out_if.width_out), 0);
      check("rst_ovf", 32'(out_if.overflow), 0);
      check("rst_ferr", 32'(out_if.frame_err), 0);
      check("rst_overrun", 32'(overrun), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_state", 32'(state_dbg), 0);
      rst_n = 1'b1;
      enable = 1'b1;
      out_if.width_ready = 1'b1;
      tick(2);

      // code 5, done coincident with fall; latency and single-cycle valid
      first_valid_cyc = -1;
      valid_cnt = 0;
      send_frame(6, 0, 1'b1);
      check("t1_latency", 32'(first_valid_cyc - done_cyc), SYNC_STAGES + 1);
      check("t1_valid_cycles", 32'(valid_cnt), 1);
      check("t1_drained", 32'(exp_q.size()), 0);

      // shortest pulse and saturation
      send_frame(1, 0, 1'b1);
      send_frame(300, 0, 1'b1);
      check("t2_drained", 32'(exp_q.size()), 0);

      // missing done strobe
      send_frame(4, NO_DONE, 1'b1);
      check("t3_drained", 32'(exp_q.size()), 0);

      // output full: second result dropped
      out_if.width_ready = 1'b0;
      ovr_cnt = 0;
      send_frame(4, 0, 1'b1);
      send_frame(8, 0, 1'b0);
      check("t4_overrun_cnt", 32'(ovr_cnt), 1);
      check("t4_hold_valid", 32'(out_if.width_valid), 1);
      check("t4_hold_width", 32'(out_if.width_out), 3);
      out_if.width_ready = 1'b1;
      tick(2);
      check("t4_valid_drop", 32'(out_if.width_valid), 0);
      check("t4_drained", 32'(exp_q.size()), 0);

      // abort by enable, then pulse already high when enable rises
      valid_cnt = 0;
      pulse_in = 1'b1;
      tick(4);
      check("t5_busy_meas", 32'(busy), 1);
      enable = 1'b0;
      tick(1);
      check("t5_busy_abort", 32'(busy), 0);
      tick(2);
      pulse_in = 1'b0;
      done_in = 1'b1;
      tick(1);
      done_in = 1'b0;
      tick(6);
      pulse_in = 1'b1;
      tick(4);
      enable = 1'b1;
      tick(4);
      check("t5_busy_ignored", 32'(busy), 0);
      pulse_in = 1'b0;
      done_in = 1'b1;
      tick(1);
      done_in = 1'b0;
      tick(6);
      check("t5_no_valid", 32'(valid_cnt), 0);
      send_frame(3, 0, 1'b1);
      check("t5_drained", 32'(exp_q.size()), 0);

      // asynchronous reset mid-measurement with a held result
      out_if.width_ready = 1'b0;
      send_frame(5, 0, 1'b1);
      check("t6_held_valid", 32'(out_if.width_valid), 1);
      pulse_in = 1'b1;
      tick(5);
      check("t6_busy", 32'(busy), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_rst_valid", 32'(out_if.width_valid), 0);
      check("t6_rst_width", 32'(out_if.width_out), 0);
      check("t6_rst_busy", 32'(busy), 0);
      check("t6_rst_state", 32'(state_dbg), 0);
      exp_q.delete();
      pulse_in = 1'b0;
      tick(2);
      rst_n = 1'b1;
      out_if.width_ready = 1'b1;
      tick(2);
      send_frame(10, 0, 1'b1);
      check("t6_drained", 32'(exp_q.size()), 0);

      // randomized frames
      ovr_cnt = 0;
      for (int i = 0; i < 30; i++) begin
         int h, d;
         h = $urandom_range(1, 40);
         d = $urandom_range(0, 4);
         if (d == 4) d = NO_DONE;
         send_frame(h, d, 1'b1);
      end
      check("rand_drained", 32'(exp_q.size()), 0);
      check("rand_no_overrun", 32'(ovr_cnt), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/pwm_width_decoder.md
Name: pwm_width_decoder

Overview:
- Downstream receive stage for the pulse-width encoder.
- Samples the encoder's pulse and done strobe, measures the pulse high time in clk cycles, and recovers the encoded value.
- Presents the recovered value, with error flags, on a valid/ready output register for the next consumer (display or loopback checker).

Parameters:
- CNT_W, 8, width of the high-time counter and width_out.
- OFFSET, 1, subtracted from the measured high-cycle count. The encoder emits N+1 high cycles for code N.
- SYNC_STAGES, 2, flop stages on each asynchronous input. Minimum 2.
- DONE_WINDOW, 2, number of cycles, counted from the falling-edge cycle, in which done_in must be seen.

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, asynchronous active-low reset.
- pulse_in, input, 1, encoder pulse. Asynchronous to clk; synchronised internally.
- done_in, input, 1, encoder done strobe. Synchronised with the same depth as pulse_in.
- enable, input, 1, measurement enable.
- width_out, output, CNT_W, recovered code.
- width_valid, output, 1, width_out and flags are valid.
- width_ready, input, 1, consumer accepts the result.
- overflow, output, 1, counter saturated during this measurement. Qualified by width_valid.
- frame_err, output, 1, done_in was not seen within DONE_WINDOW. Qualified by width_valid.
- overrun, output, 1, one-cycle pulse when a result is dropped.
- busy, output, 1, FSM is not in IDLE.

Behaviour:
- Reset values (rst_n low, asynchronous): every flop cleared.
  - All outputs 0, FSM in IDLE, counter 0.
  - Synchroniser and edge-detect history registers 0.
- Input synchronisers:
  - pulse_s and done_s are pulse_in and done_in delayed by SYNC_STAGES flops.
  - pulse_d holds the previous cycle's pulse_s and updates every cycle.
  - Rising edge = pulse_s & ~pulse_d.
- State IDLE:
  - On rising edge with enable=1: go to MEASURE, count <= 1, ovf <= 0.
  - A pulse already high when enable rises is ignored until the next rising edge.
- State MEASURE:
  - While pulse_s=1: count <= count+1, saturating at 2^CNT_W-1.
  - An increment attempted at saturation sets ovf.
  - When pulse_s=0 (the fall cycle):
    - If done_s=1 in the same cycle, publish with frame_err=0.
    - Otherwise go to WAIT_DONE with win <= 1.
- State WAIT_DONE:
  - If done_s=1, publish with frame_err=0.
  - Otherwise, if win == DONE_WINDOW-1, publish with frame_err=1.
  - Otherwise win <= win+1.
  - A new rising edge in WAIT_DONE publishes with frame_err=1 and is not captured as a new measurement.
- Publish:
  - Result = count-OFFSET if count >= OFFSET, else 0, truncated to CNT_W.
  - FSM returns to IDLE.
  - Output register is free (width_valid=0, or width_valid & width_ready in the same cycle): on the next edge load width_out, overflow and frame_err, and set width_valid=1.
  - Output register is full and width_ready=0: drop the new result, hold the old one, and pulse overrun for one cycle.
- Output handshake:
  - width_valid stays high and width_out/flags stay stable until width_valid & width_ready.
  - On that cycle width_valid falls on the next edge, unless a publish reloads it in the same cycle.
- enable low in MEASURE or WAIT_DONE: abort to IDLE on the next edge. No publish, output register untouched.
- busy = (state != IDLE). It is registered-state derived.
- Latency: a result becomes valid SYNC_STAGES+1 cycles after the encoder's done cycle at pulse_in/done_in.
- Internal FSM encoding is 2 bits. The unused encoding returns to IDLE.

Test Plan:
- Encoder sends code 5 (pulse high 6 cycles, done coincident with fall), enable=1, width_ready=1 -> width_out=5, overflow=0, frame_err=0, width_valid high 1 cycle, 3 cycles after done_in.
- Pulse high 1 cycle -> width_out=0. Pulse high 300 cycles, CNT_W=8 -> width_out=254, overflow=1.
- Pulse high 4 cycles, done_in never asserted -> after the DONE_WINDOW=2 cycle window: width_out=3, frame_err=1.
- width_ready=0, two consecutive codes 3 then 7 -> width_out holds 3, overrun pulses once. Raise width_ready -> 3 accepted, width_valid drops.
- enable dropped mid-pulse -> busy falls next cycle, no width_valid. Pulse already high when enable rises -> ignored; next code 2 measured as 2.
- rst_n low mid-measurement (asynchronous, between edges) -> all outputs 0 immediately, FSM in IDLE. After release, the next code 9 decodes as 9.
